// File: rtl/union_best_tracker.sv
// Best-coverage tracker behind the popcount stage: aligns candidate tags with results,
// keeps the running maximum per sweep. Optional UNION_BEST_EARLY_EXIT_EN ends a sweep on a full count.
module union_best_tracker #(
  parameter int unsigned TAG_W = 12,
  parameter int unsigned LAT   = 2,
  parameter int unsigned N_PTS = 40
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             cnt_valid,
  input  logic [5:0]       cnt,
  output logic             busy,
  output logic             best_valid,
  output logic [5:0]       best_count,
  output logic [TAG_W-1:0] best_tag,
  output logic             sync_err
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [5:0] N_MAX = 6'(N_PTS);
`ifdef UNION_BEST_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [LAT-1:0]   dl_vld, dl_first, dl_last;
  logic [TAG_W-1:0] dl_tag [LAT];
  logic [5:0]       run_best, best_d, cnt_sat;
  logic [TAG_W-1:0] run_tag, tag_d;
  logic             load_out, accept, full_hit;
  logic             t_vld, t_first, t_last;
  logic [TAG_W-1:0] t_tag;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dl_vld   <= '0;
      dl_first <= '0;
      dl_last  <= '0;
      for (int unsigned i = 0; i < LAT; i++) dl_tag[i] <= '0;
    end else begin
      dl_vld[0]   <= in_valid;
      dl_first[0] <= in_first & in_valid;
      dl_last[0]  <= in_last & in_valid;
      dl_tag[0]   <= in_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        dl_vld[i]   <= dl_vld[i-1];
        dl_first[i] <= dl_first[i-1];
        dl_last[i]  <= dl_last[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  assign t_vld   = dl_vld[LAT-1];
  assign t_first = dl_first[LAT-1];
  assign t_last  = dl_last[LAT-1];
  assign t_tag   = dl_tag[LAT-1];

  // A mismatched tail and cnt_valid never both read 1, so accept already discards the entry.
  assign accept   = t_vld & cnt_valid;
  assign cnt_sat  = (cnt > N_MAX) ? N_MAX : cnt;
  assign full_hit = EARLY_EXIT && (cnt_sat == N_MAX);

  always_comb begin
    state_d  = state_q;
    best_d   = run_best;
    tag_d    = run_tag;
    load_out = 1'b0;
    case (state_q)
      SWEEP: begin
        if (accept) begin
          if (t_first || (cnt_sat > run_best)) begin
            best_d = cnt_sat;
            tag_d  = t_tag;
          end
          if (t_last || full_hit) begin
            state_d  = DONE;
            load_out = 1'b1;
          end
        end
      end
      default: begin
        // DONE shares IDLE rules so a first entry arriving during the pulse starts the next sweep.
        state_d = IDLE;
        if (accept && t_first) begin
          best_d = cnt_sat;
          tag_d  = t_tag;
          if (t_last || full_hit) begin
            state_d  = DONE;
            load_out = 1'b1;
          end else begin
            state_d = SWEEP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      run_best   <= '0;
      run_tag    <= '0;
      best_count <= '0;
      best_tag   <= '0;
      sync_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_best <= best_d;
      run_tag  <= tag_d;
      if (load_out) begin
        best_count <= best_d;
        best_tag   <= tag_d;
      end
      if (t_vld != cnt_valid) sync_err <= 1'b1;
    end
  end

  assign best_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_union_best_tracker.sv
// Bench for union_best_tracker: sweep-level reference model driven from the issue side,
// per-cycle compare process, directed cases with literal expectations plus random traffic.
module tb_union_best_tracker;
  localparam int LAT   = 2;
  localparam int TAG_W = 12;
  localparam int MAXC  = 8192;
`ifdef UNION_BEST_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             RST;
  logic             in_valid, in_first, in_last, cnt_valid;
  logic [TAG_W-1:0] in_tag;
  logic [5:0]       cnt;
  logic             busy, best_valid, sync_err;
  logic [5:0]       best_count;
  logic [TAG_W-1:0] best_tag;

  always #5 clk = ~clk;

  union_best_tracker #(.TAG_W(TAG_W), .LAT(LAT), .N_PTS(40)) dut (
    .clk(clk), .RST(RST), .in_valid(in_valid), .in_tag(in_tag), .in_first(in_first),
    .in_last(in_last), .cnt_valid(cnt_valid), .cnt(cnt), .busy(busy),
    .best_valid(best_valid), .best_count(best_count), .best_tag(best_tag), .sync_err(sync_err)
  );

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // popcount emulation schedule and expected outputs, indexed by cycle
  bit         sched_v [MAXC];
  logic [5:0] sched_c [MAXC];
  bit         exp_v   [MAXC];
  int         exp_c   [MAXC];
  int         exp_t   [MAXC];
  bit         exp_b   [MAXC];
  bit in_sw = 1'b0;
  int sw_start = 0, agg = 0, aggtag = 0;
  int sync_from = 1 << 30;
  int hold_c = 0, hold_t = 0;
  bit run_chk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Sweep semantics in issue order: results come back in the same order, LAT cycles later.
  task automatic model(input int c, input int tag, input bit f, input bit l, input int k);
    int sat, p;
    sat = (k > 40) ? 40 : k;
    if (f) begin
      if (!in_sw) sw_start = c + LAT + 1;
      in_sw = 1'b1; agg = sat; aggtag = tag;
    end else if (in_sw && sat > agg) begin
      agg = sat; aggtag = tag;
    end
    if (in_sw && (l || (EE && sat == 40))) begin
      p = c + LAT + 1;
      exp_v[p] = 1'b1; exp_c[p] = agg; exp_t[p] = aggtag;
      for (int i = sw_start; i <= p; i++) exp_b[i] = 1'b1;
      in_sw = 1'b0;
    end
  endtask

  task automatic issue(input bit v, input int tag, input bit f, input bit l, input int k, input bit fault);
    in_valid = v; in_tag = tag[TAG_W-1:0]; in_first = f; in_last = l;
    cnt_valid = sched_v[cyc] | fault;
    cnt = sched_v[cyc] ? sched_c[cyc] : 6'($urandom_range(0, 63));
    if (fault && (cyc + 1 < sync_from)) sync_from = cyc + 1;
    if (v) begin
      sched_v[cyc+LAT] = 1'b1;
      sched_c[cyc+LAT] = 6'(k);
      model(cyc, tag[TAG_W-1:0], f, l, k);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    issue(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic idle_until(input int target);
    for (int n = 0; n < 64 && cyc < target; n++) idle();
  endtask

  always @(negedge clk) begin
    if (run_chk && !RST) begin
      if (exp_v[cyc]) begin hold_c = exp_c[cyc]; hold_t = exp_t[cyc]; end
      check("best_valid", best_valid, exp_v[cyc]);
      check("best_count", best_count, hold_c);
      check("best_tag",   best_tag,   hold_t);
      check("busy",       busy,       exp_b[cyc] || (in_sw && cyc >= sw_start));
      check("sync_err",   sync_err,   cyc >= sync_from);
    end
  end

  int t0, r, k;

  initial begin
    RST = 1'b1; in_valid = 0; in_tag = '0; in_first = 0; in_last = 0; cnt_valid = 0; cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", best_valid, 0);
    check("rst_count", best_count, 0);
    check("rst_tag", best_tag, 0);
    check("rst_sync", sync_err, 0);
    RST = 1'b0;
    run_chk = 1'b1;
    idle(); idle();

    // single sweep, tie keeps earlier tag
    issue(1, 1, 1, 0, 10, 0);
    issue(1, 2, 0, 0, 25, 0);
    issue(1, 3, 0, 0, 25, 0);
    t0 = cyc;
    issue(1, 4, 0, 1, 7, 0);
    idle_until(t0 + 3);
    check("s1_valid", best_valid, 1);
    check("s1_count", best_count, 25);
    check("s1_tag", best_tag, 2);
    idle();
    check("s1_once", best_valid, 0);
    idle(); idle();

    // one-candidate sweep
    t0 = cyc;
    issue(1, 9, 1, 1, 40, 0);
    idle_until(t0 + 2);
    check("s2_busy_pre", busy, 0);
    idle();
    check("s2_valid", best_valid, 1);
    check("s2_busy", busy, 1);
    check("s2_count", best_count, 40);
    check("s2_tag", best_tag, 9);
    idle();
    check("s2_busy_post", busy, 0);
    idle(); idle();

    // back-to-back sweeps
    issue(1, 30, 1, 0, 5, 0);
    issue(1, 31, 0, 0, 33, 0);
    t0 = cyc;
    issue(1, 32, 0, 1, 20, 0);
    issue(1, 40, 1, 0, 17, 0);
    issue(1, 41, 0, 1, 3, 0);
    idle_until(t0 + 3);
    check("b2b_a_valid", best_valid, 1);
    check("b2b_a_count", best_count, 33);
    check("b2b_a_tag", best_tag, 31);
    idle();
    check("b2b_gap", best_valid, 0);
    idle();
    check("b2b_b_valid", best_valid, 1);
    check("b2b_b_count", best_count, 17);
    check("b2b_b_tag", best_tag, 40);
    idle(); idle(); idle();

    // full-coverage candidate mid-sweep
    t0 = cyc;
    issue(1, 21, 1, 0, 12, 0);
    issue(1, 22, 0, 0, 40, 0);
    issue(1, 23, 0, 1, 39, 0);
    idle_until(t0 + 4);
    check("ee_pulse_early", best_valid, EE);
    idle();
    check("ee_pulse_late", best_valid, !EE);
    check("ee_count", best_count, 40);
    check("ee_tag", best_tag, 22);
    idle(); idle(); idle();

    // lockstep fault with empty pipeline
    issue(0, 0, 0, 0, 0, 1);
    check("sync_set", sync_err, 1);
    idle();

    repeat (600) begin
      case ($urandom_range(0, 3))
        0: k = 40;
        1: k = $urandom_range(41, 63);
        default: k = $urandom_range(0, 7) * 5;
      endcase
      issue($urandom_range(0, 9) < 7, $urandom_range(0, 4095),
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, k, 1'b0);
    end
    repeat (LAT + 3) idle();
    check("sync_sticky", sync_err, 1);

    // reset mid-sweep
    issue(1, 50, 1, 0, 10, 0);
    issue(1, 51, 0, 0, 20, 0);
    issue(1, 52, 0, 0, 30, 0);
    idle(); idle();
    check("mid_busy", busy, 1);
    #2;
    RST = 1'b1; in_valid = 0; in_first = 0; in_last = 0; cnt_valid = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", best_valid, 0);
    check("arst_count", best_count, 0);
    check("arst_tag", best_tag, 0);
    check("arst_sync", sync_err, 0);
    in_sw = 1'b0; hold_c = 0; hold_t = 0; sync_from = 1 << 30;
    for (int i = cyc; i < MAXC; i++) begin
      sched_v[i] = 1'b0; exp_v[i] = 1'b0; exp_b[i] = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    RST = 1'b0;
    idle(); idle();

    issue(1, 60, 1, 0, 8, 0);
    issue(1, 61, 0, 0, 30, 0);
    t0 = cyc;
    issue(1, 62, 0, 1, 12, 0);
    idle_until(t0 + 3);
    check("post_rst_valid", best_valid, 1);
    check("post_rst_count", best_count, 30);
    check("post_rst_tag", best_tag, 61);

    repeat (600) begin
      case ($urandom_range(0, 3))
        0: k = 40;
        1: k = $urandom_range(41, 63);
        default: k = $urandom_range(0, 7) * 5;
      endcase
      issue($urandom_range(0, 9) < 7, $urandom_range(0, 4095),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, k, 1'b0);
    end
    repeat (10) idle();
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/union_best_tracker.md
Name: union_best_tracker

Overview:
- Sits directly downstream of the 40-point popcount stage in the laser-treatment datapath.
- Each candidate pair of laser positions issues a union mask to the popcount stage. This block carries that candidate's tag and sweep markers through a delay line that matches popcount latency.
- It compares each returned coverage count against the running best and, at the end of a sweep, reports the best count and tag with a one-cycle done pulse.
- It also checks that popcount results arrive in lockstep with issued candidates.

Parameters:
- TAG_W, 12, candidate tag width (encodes the laser-position pair index).
- LAT, 2, popcount latency in cycles; sets the tag delay-line depth (legal range 1..8).
- N_PTS, 40, number of target points; the maximum legal count value.

Ports:
- clk  in  1  clock
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  candidate issued to popcount this cycle
- in_tag  in  TAG_W  tag of the issued candidate
- in_first  in  1  first candidate of a sweep (qualified by in_valid)
- in_last  in  1  last candidate of a sweep (qualified by in_valid)
- cnt_valid  in  1  popcount result valid
- cnt  in  6  popcount result, 0..40
- busy  out  1  sweep in progress (state is not IDLE)
- best_valid  out  1  one-cycle pulse: sweep result available
- best_count  out  6  best coverage count of the completed sweep
- best_tag  out  TAG_W  tag that achieved best_count
- sync_err  out  1  sticky lockstep-violation flag

Behaviour:
- Reset (RST asynchronous, active-high):
  - Clears the delay line, state goes to IDLE.
  - busy=0, best_valid=0, best_count=0, best_tag=0, sync_err=0.
  - Reset asserted mid-sweep abandons the sweep; no best_valid is produced.
- Delay line:
  - LAT-deep shift register of {vld, tag, first, last}, shifted every cycle.
  - Stage 0 loads {in_valid, in_tag, in_first&in_valid, in_last&in_valid}.
  - The tail entry is aligned with cnt_valid/cnt.
- Lockstep check:
  - If tail.vld != cnt_valid in any cycle, sync_err is set and stays set until RST.
  - When this happens, the tail entry is discarded and cnt is ignored.
- Accept condition: a result is accepted when tail.vld and cnt_valid are both 1.
- States:
  - IDLE: an accepted result with tail.first moves to SWEEP. It loads run_best=cnt and run_tag=tail.tag.
  - If that same accepted result also has tail.last (single-candidate sweep), go directly to DONE with those values.
  - Accepted results without tail.first while in IDLE are dropped.
- SWEEP, for each accepted result:
  - Update run_best/run_tag only if cnt > run_best (strict). Ties keep the earlier tag.
  - If tail.last, the compare for that entry is included and the state goes to DONE.
  - If tail.first arrives while in SWEEP, it restarts the sweep: reload from this entry with no result for the previous sweep. sync_err is not affected.
- DONE (one cycle):
  - best_valid=1; best_count/best_tag take run_best/run_tag and hold until the next best_valid.
  - Next state is IDLE.
  - An accepted result in the DONE cycle is handled with IDLE rules, so back-to-back sweeps lose no candidate.
- busy is 1 in SWEEP and DONE.
- cnt > N_PTS is treated as N_PTS (saturate) before comparison.
- Result latency: best_valid asserts 1 cycle after the accept cycle of the last entry, i.e. LAT+1 cycles after in_last issue.

Optional Feature:
- Macro: UNION_BEST_EARLY_EXIT_EN.
- Defined:
  - In SWEEP or on a first entry, an accepted cnt == N_PTS goes to DONE immediately with that tag.
  - Remaining entries of the sweep, up to and including the one with last, are dropped silently. Early-exit IDLE-drop does not set sync_err.
  - best_valid fires once per sweep.
- Not defined: the sweep always runs to last, with no early termination.

Test Plan:
- Single sweep, LAT=2, tags 1..4, counts 10,25,25,7 with last on tag 4 -> exactly one best_valid pulse 3 cycles after tag 4 issue; best_count=25, best_tag=2 (tie keeps earlier).
- One-candidate sweep (first and last both set), tag 9, count 40 -> best_valid 3 cycles after issue; best_count=40, best_tag=9; busy high for exactly that DONE cycle.
- Back-to-back sweeps: last of sweep A issued in the cycle immediately before first of sweep B -> two separate best_valid pulses, each with its own sweep's maximum; no candidate is lost.
- Lockstep fault: cnt_valid forced high one cycle with no candidate in flight -> sync_err=1 from the next cycle and stays 1 through later sweeps until RST.
- RST asserted mid-sweep after 3 candidates -> all outputs 0 asynchronously; no best_valid; the next full sweep reports correctly.
- Early exit (macro defined), counts 12,40,39, last on the third -> best_valid right after the 40 accept with best_tag of the second candidate; no second pulse. With the macro undefined -> the pulse comes after the third candidate, still best_count=40.
